// File: rtl/pll_reconfig_ctrl_if.sv
// PLL reconfiguration management bus: single-master write port with slave stall.
interface pll_reconfig_ctrl_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Loads one of four PLL profiles over the management bus on request, then waits
// for lock (with timeout). Requests that arrive while busy queue in a 1-deep slot.
module pll_reconfig_ctrl #(
    parameter logic [511:0] PROFILE_TABLE = 512'h0,
    parameter int unsigned  LOCK_TIMEOUT  = 1000000
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic [1:0]             mode_sel,
    input  logic                   req,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             cur_mode,
    input  logic                   pll_locked,
    pll_reconfig_ctrl_if.master    mgmt
);

    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned CNT_W = (TO_W > 20) ? TO_W : 20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C,
        ST_WR_K,
        ST_WR_START,
        ST_WAIT_LOCK,
        ST_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [1:0]         cur_mode_q, cur_mode_d;
    logic [1:0]         tgt_q, tgt_d;
    logic               pend_q, pend_d;
    logic [1:0]         pend_mode_q, pend_mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               sync1_q, lk_q;

    logic               req_eff_c;
    logic [1:0]         mode_eff_c;
    logic [5:0]         wr_addr_c;
    logic [1:0]         wr_word_c;
    logic               wr_tbl_c;
    state_t             wr_next_c;
    logic [31:0]        wr_data_c;

    function automatic logic [31:0] prof_word(input logic [1:0] p, input logic [1:0] w);
        logic [8:0] base;
        base = {p, w, 5'b0};
        return PROFILE_TABLE[base +: 32];
    endfunction

    // Lock input crosses from the PLL's domain.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_q    <= sync1_q;
        end
    end

    // Per-write-state register address, data source and successor.
    always_comb begin
        wr_addr_c = 6'h00;
        wr_word_c = 2'd0;
        wr_tbl_c  = 1'b0;
        wr_next_c = ST_WAIT_LOCK;
        case (state_q)
            ST_WR_MODE:  begin wr_addr_c = 6'h00; wr_next_c = ST_WR_N; end
            ST_WR_N:     begin wr_addr_c = 6'h03; wr_word_c = 2'd0; wr_tbl_c = 1'b1; wr_next_c = ST_WR_M; end
            ST_WR_M:     begin wr_addr_c = 6'h04; wr_word_c = 2'd1; wr_tbl_c = 1'b1; wr_next_c = ST_WR_C; end
            ST_WR_C:     begin wr_addr_c = 6'h05; wr_word_c = 2'd2; wr_tbl_c = 1'b1; wr_next_c = ST_WR_K; end
            ST_WR_K:     begin wr_addr_c = 6'h07; wr_word_c = 2'd3; wr_tbl_c = 1'b1; wr_next_c = ST_WR_START; end
            ST_WR_START: begin wr_addr_c = 6'h02; wr_next_c = ST_WAIT_LOCK; end
            default:     begin wr_addr_c = 6'h00; end
        endcase
        wr_data_c = wr_tbl_c ? prof_word(tgt_q, wr_word_c) : 32'h0;
    end

    assign req_eff_c  = req | pend_q;
    assign mode_eff_c = req ? mode_sel : pend_mode_q;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        cur_mode_d  = cur_mode_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        cnt_d       = cnt_q;
        wr_d        = 1'b0;
        addr_d      = 6'h00;
        wdata_d     = 32'h0;

        if (state_q != ST_IDLE && req) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_sel;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_eff_c) begin
                    pend_d  = 1'b0;
                    error_d = 1'b0;
                    if (mode_eff_c != cur_mode_q) begin
                        tgt_d   = mode_eff_c;
                        busy_d  = 1'b1;
                        state_d = ST_WR_MODE;
                    end else begin
                        // Already loaded: finish without touching the bus.
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_WR_MODE, ST_WR_N, ST_WR_M, ST_WR_C, ST_WR_K, ST_WR_START: begin
                // First cycle in a state is the idle gap; then hold the write until accepted.
                if (!wr_q || mgmt.mgmt_waitrequest) begin
                    wr_d    = 1'b1;
                    addr_d  = wr_addr_c;
                    wdata_d = wr_data_c;
                end else begin
                    state_d = wr_next_c;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_q) begin
                    cur_mode_d = tgt_q;
                    state_d    = ST_FINISH;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
                    error_d = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cur_mode_q  <= 2'd0;
            tgt_q       <= 2'd0;
            pend_q      <= 1'b0;
            pend_mode_q <= 2'd0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cur_mode_q  <= cur_mode_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            pend_mode_q <= pend_mode_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign cur_mode            = cur_mode_q;
    assign mgmt.mgmt_write     = wr_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: profile loads, skip, stall, timeout,
// pending request and mid-sequence reset.
module tb_pll_reconfig_ctrl;

    function automatic logic [31:0] exp_word(input int p, input int w);
        return 32'hC0DE_0000 + 32'(p * 256 + w * 16 + 5);
    endfunction

    function automatic logic [511:0] mk_table();
        logic [511:0] t;
        t = '0;
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < 4; w++)
                t[(p * 4 + w) * 32 +: 32] = exp_word(p, w);
        return t;
    endfunction

    localparam logic [511:0] TABLE = mk_table();

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [1:0] mode_sel;
    logic       req;
    logic       busy, done, error;
    logic [1:0] cur_mode;
    logic       pll_locked;

    pll_reconfig_ctrl_if mgmt_bus ();

    pll_reconfig_ctrl #(
        .PROFILE_TABLE (TABLE),
        .LOCK_TIMEOUT  (100)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .mode_sel   (mode_sel),
        .req        (req),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cur_mode   (cur_mode),
        .pll_locked (pll_locked),
        .mgmt       (mgmt_bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic [5:0]  log_a[$];
    logic [31:0] log_d[$];
    logic        gap_err = 1'b0, stab_err = 1'b0, zero_err = 1'b0;
    logic        prev_done_wr = 1'b0, prev_stall = 1'b0;
    logic [5:0]  prev_a = '0;
    logic [31:0] prev_d = '0;

    // Bus monitor: logs accepted writes and flags protocol violations.
    always @(posedge clk_sys) begin
        if (!rst_n) begin
            prev_done_wr <= 1'b0;
            prev_stall   <= 1'b0;
        end else begin
            if (mgmt_bus.mgmt_write && !mgmt_bus.mgmt_waitrequest) begin
                log_a.push_back(mgmt_bus.mgmt_address);
                log_d.push_back(mgmt_bus.mgmt_writedata);
            end
            if (prev_done_wr && mgmt_bus.mgmt_write) gap_err <= 1'b1;
            if (prev_stall && (!mgmt_bus.mgmt_write || mgmt_bus.mgmt_address != prev_a ||
                               mgmt_bus.mgmt_writedata != prev_d)) stab_err <= 1'b1;
            if (!mgmt_bus.mgmt_write && (mgmt_bus.mgmt_address != 6'h0 ||
                                         mgmt_bus.mgmt_writedata != 32'h0)) zero_err <= 1'b1;
            prev_done_wr <= mgmt_bus.mgmt_write && !mgmt_bus.mgmt_waitrequest;
            prev_stall   <= mgmt_bus.mgmt_write && mgmt_bus.mgmt_waitrequest;
            prev_a       <= mgmt_bus.mgmt_address;
            prev_d       <= mgmt_bus.mgmt_writedata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_writes(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && log_a.size() < n; i++) @(negedge clk_sys);
        chk("write_count", 64'(log_a.size()), 64'(n));
    endtask

    task automatic wait_done(input int max_cyc, output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            @(negedge clk_sys);
            n = i;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic pulse_req(input logic [1:0] m);
        mode_sel = m;
        req      = 1'b1;
        @(negedge clk_sys);
        req      = 1'b0;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    initial begin
        int  n;
        bit  seen;
        int  stable;
        logic [5:0] exp_a [6];
        exp_a = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h07, 6'h02};

        rst_n = 1'b0; req = 1'b0; mode_sel = 2'd0; pll_locked = 1'b0;
        mgmt_bus.mgmt_waitrequest = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_cur_mode", 64'(cur_mode), 64'd0);
        chk("rst_write", 64'(mgmt_bus.mgmt_write), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("no_auto_reconfig", 64'(log_a.size()), 64'd0);

        // Same mode as loaded: done two cycles after req, no bus traffic.
        pulse_req(2'd0);
        chk("skip_done_early", 64'(done), 64'd0);
        chk("skip_busy1", 64'(busy), 64'd0);
        @(negedge clk_sys);
        chk("skip_done", 64'(done), 64'd1);
        chk("skip_busy2", 64'(busy), 64'd0);
        @(negedge clk_sys);
        chk("skip_done_clear", 64'(done), 64'd0);
        chk("skip_no_writes", 64'(log_a.size()), 64'd0);

        // Load profile 1, lock arrives 10 cycles after the start write.
        clear_log();
        pulse_req(2'd1);
        chk("p1_busy", 64'(busy), 64'd1);
        wait_writes(6, 40);
        for (int i = 0; i < 6; i++) chk("p1_addr", 64'(log_a[i]), 64'(exp_a[i]));
        chk("p1_d_mode", 64'(log_d[0]), 64'd0);
        for (int w = 0; w < 4; w++) chk("p1_data", 64'(log_d[w + 1]), 64'(exp_word(1, w)));
        chk("p1_d_start", 64'(log_d[5]), 64'd0);
        repeat (10) @(negedge clk_sys);
        chk("p1_wait_busy", 64'(busy), 64'd1);
        chk("p1_wait_done", 64'(done), 64'd0);
        pll_locked = 1'b1;
        wait_done(20, n, seen);
        chk("p1_done_seen", 64'(seen), 64'd1);
        chk("p1_cur_mode", 64'(cur_mode), 64'd1);
        chk("p1_error", 64'(error), 64'd0);
        chk("p1_busy_drop", 64'(busy), 64'd0);

        // Stall the M write for five cycles.
        pll_locked = 1'b0;
        repeat (3) @(negedge clk_sys);
        clear_log();
        pulse_req(2'd2);
        for (int i = 0; i < 40 && !(mgmt_bus.mgmt_write && mgmt_bus.mgmt_address == 6'h04); i++)
            @(negedge clk_sys);
        mgmt_bus.mgmt_waitrequest = 1'b1;
        stable = (mgmt_bus.mgmt_write && mgmt_bus.mgmt_address == 6'h04 &&
                  mgmt_bus.mgmt_writedata == exp_word(2, 1)) ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            if (mgmt_bus.mgmt_write && mgmt_bus.mgmt_address == 6'h04 &&
                mgmt_bus.mgmt_writedata == exp_word(2, 1)) stable++;
        end
        mgmt_bus.mgmt_waitrequest = 1'b0;
        chk("stall_stable_cycles", 64'(stable), 64'd6);
        @(negedge clk_sys);
        chk("stall_gap", 64'(mgmt_bus.mgmt_write), 64'd0);
        @(negedge clk_sys);
        chk("stall_next_wr", 64'(mgmt_bus.mgmt_write), 64'd1);
        chk("stall_next_addr", 64'(mgmt_bus.mgmt_address), 64'h05);
        chk("stall_next_data", 64'(mgmt_bus.mgmt_writedata), 64'(exp_word(2, 2)));
        wait_writes(6, 40);
        chk("stall_log_m", 64'(log_a[2]), 64'h04);
        pll_locked = 1'b1;
        wait_done(20, n, seen);
        chk("p2_done_seen", 64'(seen), 64'd1);
        chk("p2_cur_mode", 64'(cur_mode), 64'd2);

        // Lock never arrives: timeout after ~LOCK_TIMEOUT cycles.
        pll_locked = 1'b0;
        repeat (3) @(negedge clk_sys);
        clear_log();
        pulse_req(2'd3);
        wait_writes(6, 40);
        wait_done(150, n, seen);
        chk("to_done_seen", 64'(seen), 64'd1);
        chk("to_latency", 64'((n >= 95 && n <= 110) ? 1 : 0), 64'd1);
        chk("to_error", 64'(error), 64'd1);
        chk("to_cur_mode", 64'(cur_mode), 64'd2);
        chk("to_busy", 64'(busy), 64'd0);

        // New request clears error; two requests while busy, last one wins.
        clear_log();
        pulse_req(2'd0);
        chk("err_cleared", 64'(error), 64'd0);
        repeat (2) @(negedge clk_sys);
        mode_sel = 2'd2; req = 1'b1;
        @(negedge clk_sys);
        mode_sel = 2'd3;
        @(negedge clk_sys);
        req = 1'b0;
        wait_writes(6, 40);
        chk("pend_first_n", 64'(log_d[1]), 64'(exp_word(0, 0)));
        pll_locked = 1'b1;
        wait_done(20, n, seen);
        chk("pend_first_done", 64'(seen), 64'd1);
        chk("pend_first_mode", 64'(cur_mode), 64'd0);
        clear_log();
        wait_done(60, n, seen);
        chk("pend_second_done", 64'(seen), 64'd1);
        chk("pend_second_writes", 64'(log_a.size()), 64'd6);
        chk("pend_second_n", 64'(log_d[1]), 64'(exp_word(3, 0)));
        chk("pend_second_k", 64'(log_d[4]), 64'(exp_word(3, 3)));
        chk("pend_second_mode", 64'(cur_mode), 64'd3);
        repeat (10) @(negedge clk_sys);
        chk("pend_no_third", 64'(log_a.size()), 64'd6);
        chk("pend_idle_busy", 64'(busy), 64'd0);

        // Reset in the middle of the N write.
        pulse_req(2'd1);
        for (int i = 0; i < 40 && !(mgmt_bus.mgmt_write && mgmt_bus.mgmt_address == 6'h03); i++)
            @(negedge clk_sys);
        chk("midrst_at_n", 64'(mgmt_bus.mgmt_address), 64'h03);
        rst_n = 1'b0;
        #1;
        chk("midrst_write", 64'(mgmt_bus.mgmt_write), 64'd0);
        chk("midrst_addr", 64'(mgmt_bus.mgmt_address), 64'd0);
        chk("midrst_data", 64'(mgmt_bus.mgmt_writedata), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cur_mode", 64'(cur_mode), 64'd0);
        @(negedge clk_sys);
        clear_log();
        rst_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        chk("midrst_no_writes", 64'(log_a.size()), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);

        chk("gap_between_writes", 64'(gap_err), 64'd0);
        chk("stall_stability", 64'(stab_err), 64'd0);
        chk("zero_when_idle", 64'(zero_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
